// File: rtl/cameralink_pattern_send.sv
// Camera-side CameraLink test-pattern source: framed FVV/LVV/VCE video with
// x/y/frame-count RGB, paced by the grabber's cam_enable / cam_request.
module cameralink_pattern_send #(
    parameter int WIDTH    = 8,
    parameter int HEIGHT   = 4,
    parameter int FV_SETUP = 2,
    parameter int HBLANK   = 4,
    parameter int FV_HOLD  = 2,
    parameter int VBLANK   = 8,
    parameter int FREE_RUN = 1
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        cam_enable,
    input  logic        cam_request,
    input  logic [5:0]  sideband_to_camera,
    output logic        FVV,
    output logic        LVV,
    output logic        VCE,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic [15:0] frame_count,
    output logic        busy
);

    generate
        if (WIDTH < 1 || WIDTH > 65535 || HEIGHT < 1 || HEIGHT > 65535 ||
            FV_SETUP < 1 || HBLANK < 1 || FV_HOLD < 1 || VBLANK < 1) begin : g_bad_param
            $error("cameralink_pattern_send: parameter below its minimum or out of range");
        end
    endgenerate

    localparam logic [15:0] W_END      = 16'(WIDTH);
    localparam logic [15:0] H_LAST     = 16'(HEIGHT - 1);
    localparam logic [15:0] SETUP_LAST = 16'(FV_SETUP - 1);
    localparam logic [15:0] HBL_LAST   = 16'(HBLANK - 1);
    localparam logic [15:0] HOLD_LAST  = 16'(FV_HOLD - 1);
    localparam logic [15:0] VBL_LAST   = 16'(VBLANK - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_LINE,
        S_HBL,
        S_HOLD,
        S_VBL
    } state_t;

    state_t      state, state_n;
    logic [15:0] cnt, cnt_n;
    logic [15:0] x, x_n;
    logic [15:0] y, y_n;
    logic [15:0] fc_n;
    logic        req_pend, req_pend_n;
    logic        req_prev;
    logic        fvv_n, lvv_n, vce_n, busy_n;
    logic [7:0]  red_n, green_n, blue_n;
    logic        start, stall, emit, enter_setup;

    logic unused_sideband;
    assign unused_sideband = ^sideband_to_camera[5:1];

    assign stall = sideband_to_camera[0];
    assign start = cam_enable && ((FREE_RUN != 0) || req_pend);

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        x_n         = x;
        y_n         = y;
        fc_n        = frame_count;
        fvv_n       = 1'b0;
        lvv_n       = 1'b0;
        vce_n       = 1'b0;
        red_n       = '0;
        green_n     = '0;
        blue_n      = '0;
        emit        = 1'b0;
        enter_setup = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n     = S_SETUP;
                    enter_setup = 1'b1;
                end
            end
            S_SETUP: begin
                fvv_n = 1'b1;
                if (cnt == SETUP_LAST) begin
                    state_n = S_LINE;
                    emit    = 1'b1;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            S_LINE: begin
                // x counts beats already emitted; the line ends the edge after the last beat
                fvv_n = 1'b1;
                if (x == W_END) begin
                    x_n     = '0;
                    y_n     = y + 16'd1;
                    cnt_n   = '0;
                    state_n = (y == H_LAST) ? S_HOLD : S_HBL;
                end else if (stall) begin
                    lvv_n = 1'b1;
                end else begin
                    emit = 1'b1;
                end
            end
            S_HBL: begin
                fvv_n = 1'b1;
                if (cnt == HBL_LAST) begin
                    state_n = S_LINE;
                    emit    = 1'b1;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            S_HOLD: begin
                if (cnt == HOLD_LAST) begin
                    state_n = S_VBL;
                    cnt_n   = '0;
                    fc_n    = frame_count + 16'd1;
                end else begin
                    fvv_n = 1'b1;
                    cnt_n = cnt + 16'd1;
                end
            end
            S_VBL: begin
                if (cnt == VBL_LAST) begin
                    if (start) begin
                        state_n     = S_SETUP;
                        enter_setup = 1'b1;
                    end else begin
                        state_n = S_IDLE;
                    end
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        if (enter_setup) begin
            fvv_n = 1'b1;
            cnt_n = '0;
            x_n   = '0;
            y_n   = '0;
        end

        if (emit) begin
            lvv_n   = 1'b1;
            vce_n   = 1'b1;
            red_n   = x[7:0];
            green_n = y[7:0];
            blue_n  = frame_count[7:0];
            x_n     = x + 16'd1;
            cnt_n   = '0;
        end

        busy_n = (state_n != S_IDLE);
    end

    // A new rising edge wins over the clear on SETUP entry
    assign req_pend_n = (cam_request && !req_prev && cam_enable) || (req_pend && !enter_setup);

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state       <= S_IDLE;
            cnt         <= '0;
            x           <= '0;
            y           <= '0;
            req_pend    <= 1'b0;
            req_prev    <= 1'b0;
            frame_count <= '0;
            FVV         <= 1'b0;
            LVV         <= 1'b0;
            VCE         <= 1'b0;
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            x           <= x_n;
            y           <= y_n;
            req_pend    <= req_pend_n;
            req_prev    <= cam_request;
            frame_count <= fc_n;
            FVV         <= fvv_n;
            LVV         <= lvv_n;
            VCE         <= vce_n;
            red         <= red_n;
            green       <= green_n;
            blue        <= blue_n;
            busy        <= busy_n;
        end
    end

endmodule

// File: tb/tb_cameralink_pattern_send.sv
// Directed bench: free-running defaults (d0), request-triggered (d1), and a
// 300x1 wide-line instance (d2), each checked cycle by cycle against a timing model.
module tb_cameralink_pattern_send;

    logic        clk;
    logic        rst  [3];
    logic        en   [3];
    logic        req  [3];
    logic [5:0]  sb   [3];
    logic        fvv  [3];
    logic        lvv  [3];
    logic        vce  [3];
    logic [7:0]  red  [3];
    logic [7:0]  green[3];
    logic [7:0]  blue [3];
    logic [15:0] fcnt [3];
    logic        busy [3];

    int n_cmp  = 0;
    int n_fail = 0;

    cameralink_pattern_send dut_free (
        .CLOCK(clk), .RESET(rst[0]), .cam_enable(en[0]), .cam_request(req[0]),
        .sideband_to_camera(sb[0]), .FVV(fvv[0]), .LVV(lvv[0]), .VCE(vce[0]),
        .red(red[0]), .green(green[0]), .blue(blue[0]), .frame_count(fcnt[0]), .busy(busy[0])
    );

    cameralink_pattern_send #(.FREE_RUN(0)) dut_trig (
        .CLOCK(clk), .RESET(rst[1]), .cam_enable(en[1]), .cam_request(req[1]),
        .sideband_to_camera(sb[1]), .FVV(fvv[1]), .LVV(lvv[1]), .VCE(vce[1]),
        .red(red[1]), .green(green[1]), .blue(blue[1]), .frame_count(fcnt[1]), .busy(busy[1])
    );

    cameralink_pattern_send #(.WIDTH(300), .HEIGHT(1)) dut_wide (
        .CLOCK(clk), .RESET(rst[2]), .cam_enable(en[2]), .cam_request(req[2]),
        .sideband_to_camera(sb[2]), .FVV(fvv[2]), .LVV(lvv[2]), .VCE(vce[2]),
        .red(red[2]), .green(green[2]), .blue(blue[2]), .frame_count(fcnt[2]), .busy(busy[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [26:0] pat(input int d);
        return {fvv[d], lvv[d], vce[d], blue[d], green[d], red[d]};
    endfunction

    task automatic idle_check(input int d, input int cycles);
        for (int t = 0; t < cycles; t++) begin
            check($sformatf("idle_pattern d%0d t%0d", d, t), 32'(pat(d)), 32'd0);
            check($sformatf("idle_busy d%0d t%0d", d, t), 32'(busy[d]), 32'd0);
            tick();
        end
    endtask

    task automatic trigger(input int d);
        req[d] = 1'b1;
        tick();
        req[d] = 1'b0;
        tick();
    endtask

    // Expects the current observed cycle to be the first FVV=1 cycle of a frame.
    // Stall cycles [s, s+n) are inserted into a line; ncyc<=0 runs the whole period.
    task automatic run_frame(input int d, input int w, input int h, input int fc,
                             input int s, input int n, input int drop_at,
                             input int ncyc, input bit pulses);
        int flen, per, last, beats, u, l, p;
        logic ev, el, ef;
        logic [7:0] er, eg, eb;
        logic [26:0] e;
        flen  = 4 + w * h + (h - 1) * 4 + n;
        per   = flen + 8;
        last  = (ncyc > 0) ? ncyc : per;
        beats = 0;
        for (int t = 0; t < last; t++) begin
            ef = (t < flen);
            el = 1'b0;
            ev = 1'b0;
            er = 8'h00;
            eg = 8'h00;
            if (n > 0 && t >= s && t < s + n) begin
                el = 1'b1;
            end else begin
                u = (n > 0 && t >= s + n) ? t - n : t;
                if (u >= 2 && u < 2 + h * (w + 4) - 4) begin
                    l = (u - 2) / (w + 4);
                    p = (u - 2) % (w + 4);
                    if (p < w) begin
                        el = 1'b1;
                        ev = 1'b1;
                        er = p[7:0];
                        eg = l[7:0];
                    end
                end
            end
            eb = ev ? fc[7:0] : 8'h00;
            e  = {ef, el, ev, eb, eg, er};
            check($sformatf("pattern d%0d f%0d t%0d", d, fc, t), 32'(pat(d)), 32'(e));
            check($sformatf("frame_count d%0d f%0d t%0d", d, fc, t), 32'(fcnt[d]),
                  (t < flen) ? 32'(fc) : 32'(fc + 1));
            check($sformatf("busy d%0d f%0d t%0d", d, fc, t), 32'(busy[d]), 32'd1);
            if (vce[d]) beats++;
            sb[d] = {5'h1B, (n > 0 && t + 1 >= s && t + 1 < s + n)};
            if (t == drop_at) en[d] = 1'b0;
            if (pulses) req[d] = (t + 1 == 5 || t + 1 == 10 || t + 1 == 15);
            tick();
        end
        if (last == per)
            check($sformatf("beats d%0d f%0d", d, fc), 32'(beats), 32'(w * h));
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1;
            en[i]  = 1'b1;
            req[i] = 1'b0;
            sb[i]  = {5'h1B, 1'b0};
        end
        en[0] = 1'b0;
        tick();
        tick();

        // d0: reset state, then idle with cam_enable low
        check("reset_pattern", 32'(pat(0)), 32'd0);
        check("reset_frame_count", 32'(fcnt[0]), 32'd0);
        check("reset_busy", 32'(busy[0]), 32'd0);
        rst[0] = 1'b0;
        tick();
        idle_check(0, 3);

        // d0: free-run frames, a 3-cycle stall, then cam_enable dropped in line 2
        en[0] = 1'b1;
        tick();
        run_frame(0, 8, 4, 0, 0, 0, -1, 0, 1'b0);
        run_frame(0, 8, 4, 1, 0, 0, -1, 0, 1'b0);
        run_frame(0, 8, 4, 2, 17, 3, -1, 0, 1'b0);
        run_frame(0, 8, 4, 3, 0, 0, 30, 0, 1'b0);
        idle_check(0, 20);

        // d0: reset during line 2 truncates the frame; a fresh frame follows
        en[0] = 1'b1;
        tick();
        run_frame(0, 8, 4, 4, 0, 0, -1, 31, 1'b0);
        rst[0] = 1'b1;
        tick();
        check("midreset_pattern", 32'(pat(0)), 32'd0);
        check("midreset_frame_count", 32'(fcnt[0]), 32'd0);
        check("midreset_busy", 32'(busy[0]), 32'd0);
        rst[0] = 1'b0;
        tick();
        run_frame(0, 8, 4, 0, 0, 0, -1, 0, 1'b0);
        en[0] = 1'b0;

        // d1: request-triggered frames
        rst[1] = 1'b0;
        tick();
        idle_check(1, 10);
        trigger(1);
        run_frame(1, 8, 4, 0, 0, 0, -1, 0, 1'b0);
        idle_check(1, 20);
        trigger(1);
        run_frame(1, 8, 4, 1, 0, 0, -1, 0, 1'b1);
        run_frame(1, 8, 4, 2, 0, 0, -1, 0, 1'b0);
        idle_check(1, 20);
        en[1] = 1'b0;
        trigger(1);
        idle_check(1, 10);
        en[1] = 1'b1;
        idle_check(1, 10);

        // d2: 300-pixel line, red wraps past 255
        rst[2] = 1'b0;
        tick();
        run_frame(2, 300, 1, 0, 0, 0, -1, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/cameralink_pattern_send.md
Name: cameralink_pattern_send

Overview:
- Camera-side CameraLink source: generates framed video (FVV/LVV/VCE plus 24-bit RGB) from an internal test-pattern generator, paced by the frame grabber's cam_enable/cam_request.
- Sits on the camera end of the SIMBUS point-to-point CameraLink link and drives the capture device's 27-bit data bundle. Used as a synthesizable stand-in camera for frame-grabber simulations.

Parameters:
- WIDTH, 8, active pixels per line (1..65535).
- HEIGHT, 4, lines per frame (1..65535).
- FV_SETUP, 2, cycles with FVV=1, LVV=0 before the first line (>=1).
- HBLANK, 4, cycles with LVV=0 between lines (>=1).
- FV_HOLD, 2, cycles with FVV=1, LVV=0 after the last line (>=1).
- VBLANK, 8, cycles with FVV=0 after each frame (>=1).
- FREE_RUN, 1, 1 = frames back-to-back while cam_enable=1; 0 = one frame per cam_request rising edge.
- Any parameter below its minimum is an elaboration-time error.

Ports:
- CLOCK  input  1  the single clock; all state on rising edge.
- RESET  input  1  synchronous, active-high reset.
- cam_enable  input  1  grabber permits frames.
- cam_request  input  1  frame trigger (FREE_RUN=0).
- sideband_to_camera  input  6  bit0 = pixel stall; bits 5:1 ignored.
- FVV  output  1  frame valid.
- LVV  output  1  line valid.
- VCE  output  1  pixel valid.
- red  output  8  pixel x[7:0].
- green  output  8  pixel y[7:0].
- blue  output  8  frame_count[7:0].
- frame_count  output  16  completed frames, wraps 0xFFFF->0.
- busy  output  1  1 whenever state != IDLE.

Behaviour:
- All outputs are registered. On RESET (sampled high at an edge), every output is 0 after that edge, the state is IDLE, and the request latch and counters are cleared. Reset mid-frame truncates the frame immediately.
- States: IDLE, SETUP, LINE, HBL, HOLD, VBL.
- Start condition: cam_enable=1 and (FREE_RUN=1 or req_pend=1).
- IDLE: all outputs 0. If the start condition holds at edge k: FVV=1 after edge k and the state goes to SETUP.
- SETUP lasts FV_SETUP cycles (FVV=1, LVV=0, VCE=0), then goes to LINE.
- LINE:
  - LVV=1 throughout.
  - When sideband_to_camera[0]=0: VCE=1, RGB = {blue=frame_count[7:0], green=y[7:0], red=x[7:0]}, and x increments.
  - When sideband_to_camera[0]=1 (sampled at the same edge): VCE=0, RGB=0, x holds, LVV stays 1.
  - After WIDTH VCE beats: x=0, y increments. If y was HEIGHT-1, go to HOLD; otherwise go to HBL.
- Stall is effective one cycle after assertion (registered outputs). A stall arriving during SETUP, HBL or HOLD has no effect.
- HBL lasts HBLANK cycles (FVV=1, LVV=0), then goes to LINE.
- HOLD lasts FV_HOLD cycles (FVV=1, LVV=0), then goes to VBL. On that transition, FVV falls and frame_count increments in the same edge.
- VBL lasts VBLANK cycles with FVV=0. On the last VBL cycle, if the start condition holds, go directly to SETUP; otherwise go to IDLE.
- Frame length with no stalls: FVV high for FV_SETUP + WIDTH*HEIGHT + (HEIGHT-1)*HBLANK + FV_HOLD cycles. Defaults give 48 cycles.
- Free-run period with defaults: 56 cycles.
- x, y and frame-internal counters are 16 bits. RGB uses the low 8 bits, so red wraps 255->0 on lines longer than 256 pixels.
- Request latch (req_pend):
  - Set on a cam_request rising edge (registered previous value) while cam_enable=1; ignored when cam_enable=0.
  - Cleared on entry to SETUP.
  - Any number of requests during a frame collapse into one pending frame.
  - A rising edge coincident with the clear sets the latch again (set wins).
- cam_enable falling mid-frame: the current frame completes normally, including VBL, then the block goes to IDLE.
- FREE_RUN=1 ignores cam_request.

Test Plan:
- Defaults, FREE_RUN=1, cam_enable=1 after reset:
  - FVV rises one cycle after the first enabled edge, stays high 48 cycles, low 8, repeats every 56.
  - 32 VCE beats per frame; red 0..7, green 0..3; blue=0 in frame 0 and 1 in frame 1; frame_count=1 when FVV first falls.
- Stall: hold sideband_to_camera[0]=1 for 3 cycles mid-line 1.
  - VCE gaps 3 cycles, LVV stays high, x resumes with no skipped or repeated value, frame is 51 cycles long.
- FREE_RUN=0:
  - Pulse cam_request once → exactly one 48-cycle frame, then IDLE with busy=0.
  - Three pulses during that frame → exactly one further frame.
  - A pulse with cam_enable=0 → no frame.
- Drop cam_enable during line 2 → frame completes (48 FVV cycles), then the block stays IDLE.
- Assert RESET during line 2 → all outputs 0 next cycle, frame_count=0. Release with cam_enable=1 → a fresh frame starts with red=0, green=0.
- WIDTH=300, HEIGHT=1: red wraps 255→0 at pixel 256, and 300 VCE beats are produced.
